// File: rtl/game_led_reporter.sv
// Streams the four game LEDs as an ASCII line ("wxyz" CR LF) over UART 8N1.
// LED changes that arrive while a frame is in flight collapse into one follow-up report.
module game_led_reporter #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       w,
   input  logic       x,
   input  logic       y,
   input  logic       z,
   input  logic       report,
   output logic       tx,
   output logic       busy,
   output logic [7:0] coalesced
);

   // state | meaning
   // IDLE  | line high, waiting for report or LED change vs last_sent
   // START | start bit (low) for one bit time
   // DATA  | 8 data bits, LSB first
   // STOP  | stop bit (high); then next byte, or IDLE after LF
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0] s);
      logic [7:0] b;
      b = 8'h0A;
      case (idx)
         3'd0:    b = 8'h30 + {7'd0, s[3]};
         3'd1:    b = 8'h30 + {7'd0, s[2]};
         3'd2:    b = 8'h30 + {7'd0, s[1]};
         3'd3:    b = 8'h30 + {7'd0, s[0]};
         3'd4:    b = 8'h0D;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [3:0]  snap_q, snap_d;
   logic [3:0]  last_sent_q, last_sent_d;
   logic [3:0]  prev_q;
   logic [7:0]  coalesced_q, coalesced_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic [3:0]  leds;
   logic        bit_done;
   logic [7:0]  byte_d;

   assign leds     = {w, x, y, z};
   assign bit_done = (timer_q == BIT_LAST);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      snap_d      = snap_q;
      last_sent_d = last_sent_q;
      coalesced_d = coalesced_q;

      case (state_q)
         S_IDLE: begin
            if (report || (leds != last_sent_q)) begin
               snap_d      = leds;
               last_sent_d = leds;
               byte_idx_d  = 3'd0;
               bit_idx_d   = 3'd0;
               timer_d     = 16'd0;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               timer_d   = 16'd0;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               timer_d = 16'd0;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               timer_d = 16'd0;
               if (byte_idx_q == 3'd5) begin
                  state_d = S_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (busy_q && (leds != prev_q) && (coalesced_q != 8'hFF)) begin
         coalesced_d = coalesced_q + 8'd1;
      end

      // Outputs are precomputed from next state so tx/busy come straight from flops.
      byte_d = frame_byte(byte_idx_d, snap_d);
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = byte_d[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         timer_q     <= 16'd0;
         bit_idx_q   <= 3'd0;
         byte_idx_q  <= 3'd0;
         snap_q      <= 4'd0;
         last_sent_q <= 4'd0;
         prev_q      <= 4'd0;
         coalesced_q <= 8'd0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         snap_q      <= snap_d;
         last_sent_q <= last_sent_d;
         prev_q      <= leds;
         coalesced_q <= coalesced_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
      end
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign coalesced = coalesced_q;

endmodule

// File: tb/tb_game_led_reporter.sv
// Directed bench for game_led_reporter: decodes the UART line independently and
// compares frames, busy length, coalesce count and reset behaviour against fixed values.
module tb_game_led_reporter;
   localparam int CPB = 4;

   typedef struct {
      logic [3:0]  leds;
      logic        rep;
      logic [47:0] frame;
      logic [7:0]  coal;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
   logic       report = 1'b0;
   logic       tx, busy;
   logic [7:0] coalesced;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] rx_q[$];

   game_led_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .w(w), .x(x), .y(y), .z(z),
      .report(report), .tx(tx), .busy(busy), .coalesced(coalesced)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // UART receiver sampling mid-bit; bytes cut short by reset are discarded.
   initial begin
      logic [7:0] b;
      bit         ok;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            ok = ok && rst_n;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
               ok = ok && rst_n;
            end
            repeat (CPB) @(negedge clk);
            ok = ok && rst_n;
            if (ok) begin
               check("stop_bit", 64'(tx), 64'd1);
               rx_q.push_back(b);
            end
         end
      end
   end

   task automatic set_leds(input logic [3:0] v, input logic rep);
      @(posedge clk);
      #1;
      {w, x, y, z} = v;
      report = rep;
   endtask

   task automatic drop_report();
      @(posedge clk);
      #1 report = 1'b0;
   endtask

   task automatic wait_idle(output int busy_cyc, output bit done);
      busy_cyc = 0;
      done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         else begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic get_frame(output logic [47:0] f);
      f = '0;
      for (int i = 0; i < 6; i++) begin
         f = {f[39:0], (i < rx_q.size()) ? rx_q[i] : 8'hxx};
      end
   endtask

   task automatic do_reset();
      {w, x, y, z} = 4'b0000;
      report = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t        steps[6];
      logic [47:0] fr;
      int          bc, idle, cnt;
      bit          done, bad;
      logic [7:0]  prevc;

      steps[0] = '{4'b0000, 1'b1, {"0000", 8'h0D, 8'h0A}, 8'd0};
      steps[1] = '{4'b0100, 1'b0, {"0100", 8'h0D, 8'h0A}, 8'd0};
      steps[2] = '{4'b0110, 1'b0, {"0110", 8'h0D, 8'h0A}, 8'd0};
      steps[3] = '{4'b0111, 1'b0, {"0111", 8'h0D, 8'h0A}, 8'd0};
      steps[4] = '{4'b1111, 1'b0, {"1111", 8'h0D, 8'h0A}, 8'd0};
      steps[5] = '{4'b0000, 1'b1, {"0000", 8'h0D, 8'h0A}, 8'd0};

      // Reset values and a quiet line with unchanged LEDs
      rst_n = 1'b0;
      #12;
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_coalesced", 64'(coalesced), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      check("idle_quiet", 64'(bad), 64'd0);
      check("idle_no_bytes", 64'(rx_q.size()), 64'd0);

      // Single report pulse: latency, frame length, content
      rx_q.delete();
      @(posedge clk);
      #1 report = 1'b1;
      @(negedge clk);
      check("tx_before_edge", 64'(tx), 64'd1);
      @(posedge clk);
      #1 report = 1'b0;
      @(negedge clk);
      check("tx_fall", 64'(tx), 64'd0);
      check("busy_rise", 64'(busy), 64'd1);
      wait_idle(bc, done);
      check("report_done", 64'(done), 64'd1);
      check("busy_len", 64'(bc + 1), 64'd240);
      get_frame(fr);
      check("report_frame", 64'(fr), 64'({"0000", 8'h0D, 8'h0A}));
      check("report_nbytes", 64'(rx_q.size()), 64'd6);

      // Stepped LED patterns, one frame per step
      for (int i = 0; i < 6; i++) begin
         rx_q.delete();
         set_leds(steps[i].leds, steps[i].rep);
         drop_report();
         wait_idle(bc, done);
         check("step_done", 64'(done), 64'd1);
         check("step_busy_len", 64'(bc), 64'd240);
         get_frame(fr);
         check("step_frame", 64'(fr), 64'(steps[i].frame));
         check("step_nbytes", 64'(rx_q.size()), 64'd6);
         check("step_coalesced", 64'(coalesced), 64'(steps[i].coal));
      end
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (busy !== 1'b0) bad = 1'b1;
      end
      check("step_no_extra", 64'(bad), 64'd0);

      // Changes absorbed during a frame yield one follow-up with the newest value
      do_reset();
      rx_q.delete();
      set_leds(4'b0100, 1'b0);
      repeat (20) @(posedge clk);
      #1 {w, x, y, z} = 4'b0110;
      repeat (20) @(posedge clk);
      #1 {w, x, y, z} = 4'b0111;
      wait_idle(bc, done);
      check("coal_first_done", 64'(done), 64'd1);
      get_frame(fr);
      check("coal_first_frame", 64'(fr), 64'({"0100", 8'h0D, 8'h0A}));
      check("coal_count", 64'(coalesced), 64'd2);
      rx_q.delete();
      idle = 1;
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) begin
            done = 1'b1;
            break;
         end
         idle++;
      end
      check("coal_followup_start", 64'(done), 64'd1);
      check("coal_gap_ge1", 64'(idle >= 1), 64'd1);
      wait_idle(bc, done);
      check("coal_followup_len", 64'(bc + 1), 64'd240);
      get_frame(fr);
      check("coal_followup_frame", 64'(fr), 64'({"0111", 8'h0D, 8'h0A}));
      check("coal_count_after", 64'(coalesced), 64'd2);
      bad = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0) bad = 1'b1;
      end
      check("coal_single_followup", 64'(bad), 64'd0);

      // Reset during data bit 3 of byte 2
      do_reset();
      @(posedge clk);
      #1 report = 1'b1;
      @(posedge clk);
      #1 report = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 w = ~w;
      end
      repeat (94) @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      check("mid_tx_bit3", 64'(tx), 64'd0);
      check("mid_coalesced", 64'(coalesced), 64'd4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 64'(tx), 64'd1);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_coalesced", 64'(coalesced), 64'd0);
      repeat (2) @(negedge clk);
      rx_q.delete();
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      check("post_rst_quiet", 64'(bad), 64'd0);

      // Coalesce counter saturation
      do_reset();
      set_leds(4'b0000, 1'b1);
      drop_report();
      prevc = coalesced;
      bad = 1'b0;
      cnt = 0;
      repeat (300) begin
         @(posedge clk);
         #1 w = ~w;
         if (coalesced < prevc) bad = 1'b1;
         if (busy) cnt++;
         prevc = coalesced;
      end
      check("sat_no_wrap", 64'(bad), 64'd0);
      check("sat_value", 64'(coalesced), 64'd255);
      check("sat_mostly_busy", 64'(cnt >= 290), 64'd1);
      repeat (800) @(negedge clk);
      check("sat_final_idle", 64'(busy), 64'd0);
      check("sat_hold", 64'(coalesced), 64'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
